// File: rtl/alu_cmd_driver.sv
// Command FIFO feeding an external combinational ALU; keeps the accumulator and
// presents one registered result per command with a valid/ready handshake.
module alu_cmd_driver #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_load,
    input  logic [WIDTH-1:0] cmd_y,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf,
    output logic             busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

    state_t state_r, state_s;

    logic [2:0]       mem_op_r   [FIFO_DEPTH];
    logic             mem_load_r [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_y_r    [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [AW:0]      count_r;
    logic             empty_s, full_s, push_s, pop_s;
    logic [WIDTH-1:0] acc_r, result_s;
    logic             load_r;

    assign empty_s   = (count_r == {(AW+1){1'b0}});
    assign full_s    = (count_r == DEPTH_C);
    assign cmd_ready = !full_s;
    assign push_s    = cmd_valid && !full_s;
    assign busy      = (state_r != IDLE) || !empty_s;
    assign result_s  = load_r ? alu_y : alu_out;

    // FIFO storage; contents are meaningless while count_r says empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_op_r[wr_ptr_r]   <= cmd_op;
            mem_load_r[wr_ptr_r] <= cmd_load;
            mem_y_r[wr_ptr_r]    <= cmd_y;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Next-state logic; the FIFO is popped only on the IDLE->ISSUE transition.
    always_comb begin
        state_s = state_r;
        pop_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: state_s = RESP;
            RESP: begin
                if (res_ready) state_s = IDLE;
                else           state_s = RESP;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Operand capture, accumulator update and result holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_x     <= {WIDTH{1'b0}};
            alu_y     <= {WIDTH{1'b0}};
            alu_op    <= 3'b000;
            load_r    <= 1'b0;
            acc_r     <= {WIDTH{1'b0}};
            res_data  <= {WIDTH{1'b0}};
            res_ovf   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        alu_x  <= acc_r;
                        alu_y  <= mem_y_r[rd_ptr_r];
                        alu_op <= mem_op_r[rd_ptr_r];
                        load_r <= mem_load_r[rd_ptr_r];
                    end
                end
                ISSUE: begin
                    acc_r     <= result_s;
                    res_data  <= result_s;
                    res_ovf   <= result_s[WIDTH-1];
                    res_valid <= 1'b1;
                end
                RESP: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: res_valid <= 1'b0;
            endcase
        end
    end

endmodule
